// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions, MODE encodings, FSM states
// and the bridge address windows of the two timer instances.
package timer_counter_pkg;

  // Register offsets, selected by Addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // MODE encodings; 1x is reserved and behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // FSM states
  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Bridge windows of the two instances
  localparam logic [31:0] TC1_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_END  = 32'h0000_7F0B;
  localparam logic [31:0] TC2_BASE = 32'h0000_7F10;
  localparam logic [31:0] TC2_END  = 32'h0000_7F1B;

  // True only for the auto-reload encoding; reserved modes act as one-shot
  function automatic logic mode_is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer responder on a bridge peripheral port.
// CTRL/PRESET are CPU writable, COUNT is read-only; expiry raises IRQ
// when the interrupt mask bit is set.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  tc_state_e   state;

  logic [1:0]  reg_sel;
  logic        unused_addr;

  assign reg_sel     = Addr[3:2];
  assign unused_addr = ^Addr[31:4];

  // Register file and countdown FSM; a CPU CTRL write is applied last so it
  // overrides any FSM update to EN or irq_flag on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= TC_IDLE;
    end else begin
      // Auto-reload interrupt is a single-cycle pulse
      if (irq_flag && mode_is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]))
        irq_flag <= 1'b0;

      case (state)
        TC_IDLE: begin
          if (ctrl[CTRL_EN])
            state <= TC_LOAD;
        end
        TC_LOAD: begin
          count <= preset;
          state <= TC_CNT;
        end
        TC_CNT: begin
          if (!ctrl[CTRL_EN])
            state <= TC_IDLE;
          else if (count == '0)
            state <= TC_INT;
          else
            count <= count - 32'd1;
        end
        TC_INT: begin
          state    <= TC_IDLE;
          irq_flag <= 1'b1;
          if (!mode_is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]))
            ctrl[CTRL_EN] <= 1'b0;
        end
        default: state <= TC_IDLE;
      endcase

      if (WE) begin
        case (reg_sel)
          TC_CTRL: begin
            ctrl     <= Din[3:0];
            irq_flag <= 1'b0;
          end
          TC_PRESET: preset <= Din;
          default: ;
        endcase
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    Dout = '0;
    case (reg_sel)
      TC_CTRL:   Dout = {28'd0, ctrl};
      TC_PRESET: Dout = preset;
      TC_COUNT:  Dout = count;
      default:   Dout = '0;
    endcase
  end

  // Interrupt request gated by the mask bit
  always_comb begin
    IRQ = ctrl[CTRL_IM] & irq_flag;
  end

endmodule
